// File: rtl/mem_responder.sv
// mem_responder: target-side responder for the en/wr/addr request bus.
// Services requests against an internal register array after wait states.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   en, wr            request valid, 1 = write / 0 = read
//   addr, wdata       word address, write data
//   rdata             read data, held until the next read response
//   ack, err          one-cycle response strobe, out-of-range flag
//   busy              high while waiting; en is ignored then
//   wr_count          saturating count of in-range writes
//   rd_count          saturating count of in-range reads
module mem_responder #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 48,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [7:0]        wr_count,
    output logic [7:0]        rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0]      WC   = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] LIM  = (ADDR_W+1)'(DEPTH);

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   a_q;
    logic                wr_q;
    logic [DATA_W-1:0]   d_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                in_range;
    logic                take;

    // Full-width compare: no aliasing of high addresses onto the array.
    assign in_range = {1'b0, a_q} < LIM;

    // A new request is accepted from IDLE, or back-to-back on the
    // edge that completes the previous one.
    assign take = en && (state == IDLE || state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            wr_q     <= 1'b0;
            d_q      <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            rdata    <= '0;
            wr_count <= '0;
            rd_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ack <= 1'b0;
            err <= 1'b0;

            // RESP is the cycle whose closing edge commits the request
            // and raises ack/err for the following cycle.
            if (state == RESP) begin
                ack <= 1'b1;
                err <= !in_range;
                if (in_range) begin
                    if (wr_q) begin
                        mem[a_q] <= d_q;
                        if (wr_count != 8'hFF) begin
                            wr_count <= wr_count + 8'd1;
                        end
                    end else begin
                        rdata <= mem[a_q];
                        if (rd_count != 8'hFF) begin
                            rd_count <= rd_count + 8'd1;
                        end
                    end
                end else if (!wr_q) begin
                    rdata <= '0;
                end
            end

            unique case (1'b1)
                take: begin
                    a_q  <= addr;
                    wr_q <= wr;
                    d_q  <= wdata;
                    cnt  <= WC;
                    if (WC == 4'd0) begin
                        state <= RESP;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                state == WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder.
// Drives a WAIT_CYCLES=1 and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    localparam int W1 = 1;
    localparam int W0 = 0;

    typedef struct {
        bit       err;
        bit [7:0] rdata;
        int       wc;
        int       rc;
        int       cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         t5 = 1'b0;

    logic       en1 = 1'b0, wr1 = 1'b0;
    logic [5:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic [7:0] rdata1, wrc1, rdc1;
    logic       ack1, err1, busy1;

    logic       en0 = 1'b0, wr0 = 1'b0;
    logic [5:0] addr0 = '0;
    logic [7:0] wdata0 = '0;
    logic [7:0] rdata0, wrc0, rdc0;
    logic       ack0, err0, busy0;

    exp_t q1[$];
    exp_t q0[$];

    bit [7:0] mm [2][64];
    int       mwc [2];
    int       mrc [2];
    bit [7:0] mlast [2];

    mem_responder #(.WAIT_CYCLES(W1)) u1 (
        .clk(clk), .rst(rst), .en(en1), .wr(wr1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1),
        .ack(ack1), .err(err1), .busy(busy1),
        .wr_count(wrc1), .rd_count(rdc1)
    );

    mem_responder #(.WAIT_CYCLES(W0)) u0 (
        .clk(clk), .rst(rst), .en(en0), .wr(wr0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0),
        .ack(ack0), .err(err0), .busy(busy0),
        .wr_count(wrc0), .rd_count(rdc0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a 48-word array with saturating counters.
    function automatic exp_t model(int u, bit w, bit [5:0] a,
                                   bit [7:0] d, int ecyc);
        exp_t e;
        e.cyc = ecyc;
        e.err = (a >= 6'd48);
        if (!e.err) begin
            if (w) begin
                mm[u][a] = d;
                if (mwc[u] < 255) mwc[u]++;
            end else begin
                mlast[u] = mm[u][a];
                if (mrc[u] < 255) mrc[u]++;
            end
        end else if (!w) begin
            mlast[u] = 8'h00;
        end
        e.rdata = mlast[u];
        e.wc    = mwc[u];
        e.rc    = mrc[u];
        return e;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 64; i++) mm[u][i] = 8'h00;
            mwc[u]   = 0;
            mrc[u]   = 0;
            mlast[u] = 8'h00;
        end
        q1.delete();
        q0.delete();
    endtask

    task automatic chk(string n, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, req);
        end
    endtask

    task automatic check_ack(string n, exp_t e, logic er,
                             logic [7:0] rd, logic [7:0] wc,
                             logic [7:0] rc);
        total++;
        if (e.err !== er || e.rdata !== rd || e.wc != int'(wc) ||
            e.rc != int'(rc) || e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: got err=%0b rdata=%h wr=%0d rd=%0d cyc=%0d want err=%0b rdata=%h wr=%0d rd=%0d cyc=%0d",
                     n, er, rd, wc, rc, cyc,
                     e.err, e.rdata, e.wc, e.rc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ack1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_ack1: got ack=1 want ack=0 cyc=%0d", cyc);
                end else begin
                    check_ack("resp1", q1.pop_front(), err1,
                              rdata1, wrc1, rdc1);
                end
            end
            if (ack0) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_ack0: got ack=1 want ack=0 cyc=%0d", cyc);
                end else begin
                    check_ack("resp0", q0.pop_front(), err0,
                              rdata0, wrc0, rdc0);
                end
            end
            if (t5) chk("busy0_never", int'(busy0), 0);
        end
    end

    // One isolated request on the WAIT_CYCLES=1 instance.
    task automatic req1(bit w, bit [5:0] a, bit [7:0] d);
        @(negedge clk);
        en1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
        q1.push_back(model(1, w, a, d, cyc + W1 + 2));
        @(negedge clk);
        en1 = 1'b0;
        repeat (W1) @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_ack", int'(ack1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_rdata", int'(rdata1), 0);
        chk("rst_wr_count", int'(wrc1), 0);
        chk("rst_rd_count", int'(rdc1), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Basic write then read-back.
        req1(1'b1, 6'h0C, 8'hA5);
        req1(1'b0, 6'h0C, 8'h00);

        // Out-of-range and boundary word.
        req1(1'b0, 6'h30, 8'h00);
        req1(1'b1, 6'h38, 8'hFF);
        req1(1'b1, 6'h2F, 8'h5A);
        req1(1'b0, 6'h2F, 8'h00);

        // Back-to-back with junk presented while busy.
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b0; addr1 = 6'h0E; wdata1 = 8'h00;
        q1.push_back(model(1, 1'b0, 6'h0E, 8'h00, cyc + W1 + 2));
        @(negedge clk);
        wr1 = 1'b1; addr1 = 6'h01; wdata1 = 8'h99;
        @(negedge clk);
        wr1 = 1'b1; addr1 = 6'h17; wdata1 = 8'h3C;
        q1.push_back(model(1, 1'b1, 6'h17, 8'h3C, cyc + W1 + 2));
        @(negedge clk);
        en1 = 1'b0;
        repeat (W1) @(negedge clk);
        req1(1'b0, 6'h01, 8'h00);

        // Reset in the middle of a write's wait state.
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b1; addr1 = 6'h17; wdata1 = 8'h3C;
        @(negedge clk);
        en1 = 1'b0;
        chk("busy_in_wait", int'(busy1), 1);
        do_reset();
        req1(1'b0, 6'h17, 8'h00);

        // Zero-wait instance: ack every cycle, alternating w/r.
        t5 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en0 = 1'b1; wr0 = (i % 2 == 0); addr0 = 6'h05;
            wdata0 = 8'($urandom);
            q0.push_back(model(0, wr0, 6'h05, wdata0, cyc + W0 + 2));
        end
        @(negedge clk);
        en0 = 1'b0;
        @(negedge clk);
        t5 = 1'b0;

        // Random mixed traffic, including out-of-range addresses.
        for (int i = 0; i < 150; i++) begin
            req1(1'($urandom), 6'($urandom_range(0, 63)),
                 8'($urandom));
        end

        // Counter saturation.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req1(1'b1, 6'($urandom_range(0, 47)), 8'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q0", q0.size(), 0);
        chk("wr_count_sat", int'(wrc1), 255);
        chk("rd_count_zero", int'(rdc1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target-side responder for the en/wr/addr bus driven by the team's stimulus tasks.
- Samples requests on the rising clock edge and services them against an internal register array after a fixed number of wait states.
- Returns a one-cycle ack, read data and an address-range error.
- Keeps saturating counts of completed reads and writes for scoreboarding.

Parameters:
- ADDR_W, 6, width of addr.
- DATA_W, 8, width of wdata and rdata.
- DEPTH, 48, number of implemented words. Addresses DEPTH..2**ADDR_W-1 are out of range.
- WAIT_CYCLES, 1, wait states between capture and response. Legal range is 0..15.

Ports:
- clk  in  1  single clock. All sampling happens on posedge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  request valid.
- wr  in  1  1 = write, 0 = read. Qualified by en.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data. Qualified by en & wr.
- rdata  out  DATA_W  read data. Holds its value until the next read response.
- ack  out  1  one-cycle response strobe.
- err  out  1  valid only with ack. 1 = address out of range.
- busy  out  1  high while in WAIT. en is ignored while busy.
- wr_count  out  8  successful writes, saturating.
- rd_count  out  8  successful reads, saturating.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - state = IDLE.
  - ack, err, busy, rdata, wr_count, rd_count all 0.
  - All DEPTH words of the array cleared to 0.
  - A pending request is dropped: no write commit, no ack.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - On a posedge with en=1, capture addr, wr, wdata.
  - Load cnt = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
  - With en=0, stay in IDLE.
- WAIT:
  - busy=1. en, addr, wr and wdata are ignored.
  - cnt decrements on each edge. On the edge where cnt == 1, go to RESP.
  - Exactly WAIT_CYCLES cycles are spent in WAIT.
- Entering RESP (edge T0+WAIT_CYCLES+1, where T0 is the capture edge), on that edge:
  - ack <= 1.
  - err <= (captured addr >= DEPTH).
  - In-range write: array[addr] <= wdata, and wr_count increments.
  - In-range read: rdata <= array[addr], and rd_count increments.
  - Out-of-range write: no array change.
  - Out-of-range read: rdata <= 0.
  - Out-of-range requests do not change either counter.
- RESP lasts one cycle, and ack/err are high for that cycle only.
  - If en=1 at the edge leaving RESP, the new request is captured as in IDLE (back-to-back).
  - Otherwise go to IDLE, and ack and err drop to 0.
- Throughput:
  - WAIT_CYCLES=0 with en held high gives one ack per cycle.
  - In general, one request per WAIT_CYCLES+1 cycles.
- Read-after-write: a read captured on the ack edge of a write to the same address returns the new data.
- Counters saturate at 255 and never wrap.
- addr is compared at full ADDR_W width. No truncation or aliasing.

Test Plan:
1. WAIT_CYCLES=1. Write addr 0x0C with wdata 0xA5, then read 0x0C.
   - Each ack arrives 2 edges after its capture edge and lasts 1 cycle, with err=0.
   - Read returns rdata=0xA5. wr_count=1, rd_count=1.
2. Read addr 0x30 and write addr 0x38 with wdata 0xFF; then write addr 0x2F with wdata 0x5A and read it back.
   - The 0x30 read and 0x38 write each get ack with err=1. rdata=0x00 and counters are unchanged.
   - The boundary word 0x2F reads back 0x5A with err=0.
3. Hold en=1 through the response: request 1 is read 0x0E, request 2 is write 0x17 with 0x3C presented on the ack edge.
   - Request 2 is captured on request 1's ack edge, and its ack follows 2 edges later.
   - en pulses while busy=1 produce no extra ack.
4. Assert rst mid-WAIT of a write to 0x17 with wdata 0x3C.
   - All outputs are 0 before the next clock edge.
   - After release, a read of 0x17 returns 0x00 and wr_count=0.
5. WAIT_CYCLES=0 instance with en held high for 10 cycles, alternating write/read on 0x05.
   - ack is high on 10 consecutive cycles and busy never asserts.
   - Each read returns the preceding write's data.
6. 300 in-range writes.
   - wr_count stops at 255. rd_count remains 0.
